// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
// Both writeback sources are carried internally as wb_req_t.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned WB_DATA_W  = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

    // x0 is architecturally zero and never tracked as a pending destination.
    function automatic logic is_trackable(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// Provides registered source-hazard lookups and the WAW check for the issuing rd.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_long_i,
    input  logic                  issue_stall_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  lsu_xfer_i,
    input  logic [REG_ADDR_W-1:0] lsu_rd_i,
    input  logic [REG_ADDR_W-1:0] rs_a_i,
    input  logic [REG_ADDR_W-1:0] rs_b_i,
    output logic                  hazard_o,
    output logic                  waw_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             set_en;

    always_comb begin
        set_en = issue_valid_i & issue_long_i & ~issue_stall_i & is_trackable(issue_rd_i);
    end

    // Clear is applied before set so a same-index set wins.
    always_comb begin
        pending_d = pending_q;
        if (lsu_xfer_i) begin
            pending_d[lsu_rd_i] = 1'b0;
        end
        if (set_en) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        hazard_o = pending_q[rs_a_i] | pending_q[rs_b_i];
        // A transfer to the same rd this cycle retires the older write in time.
        waw_o    = issue_valid_i & pending_q[issue_rd_i]
                   & ~(lsu_xfer_i & (lsu_rd_i == issue_rd_i));
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and long-latency writeback onto the single register-file write port,
// with a starvation counter that throttles issue when the LSU is refused too long.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned DATA_W   = WB_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_valid_i,
    input  logic [REG_ADDR_W-1:0] alu_rd_i,
    input  logic [DATA_W-1:0]     alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_rd_i,
    input  logic [DATA_W-1:0]     lsu_data_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_long_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic [REG_ADDR_W-1:0] rs_a_i,
    input  logic [REG_ADDR_W-1:0] rs_b_i,
    output logic                  hazard_o,
    output logic                  issue_stall_o,
    output logic                  rd_we_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0]     rd_data_o
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    wb_req_t    alu_req;
    wb_req_t    lsu_req;
    wb_req_t    wb_sel;
    logic       lsu_xfer;
    logic       waw;
    logic       throttle;
    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    always_comb begin
        alu_req.valid = alu_valid_i;
        alu_req.rd    = alu_rd_i;
        alu_req.data  = alu_data_i;
        lsu_req.valid = lsu_valid_i;
        lsu_req.rd    = lsu_rd_i;
        lsu_req.data  = lsu_data_i;
    end

    always_comb begin
        wb_sel = lsu_req;
        if (alu_req.valid) begin
            wb_sel = alu_req;
        end
        rd_we_o     = alu_req.valid | lsu_req.valid;
        rd_addr_o   = wb_sel.rd;
        rd_data_o   = wb_sel.data;
        lsu_ready_o = lsu_req.valid & ~alu_req.valid;
        lsu_xfer    = lsu_req.valid & lsu_ready_o;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!lsu_valid_i || lsu_xfer) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        throttle      = (wait_cnt_q == MAX_WAIT_C);
        issue_stall_o = hazard_o | waw | throttle;
    end

    wb_scoreboard u_scoreboard (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .issue_long_i  (issue_long_i),
        .issue_stall_i (issue_stall_o),
        .issue_rd_i    (issue_rd_i),
        .lsu_xfer_i    (lsu_xfer),
        .lsu_rd_i      (lsu_rd_i),
        .rs_a_i        (rs_a_i),
        .rs_b_i        (rs_b_i),
        .hazard_o      (hazard_o),
        .waw_o         (waw)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, scoreboard hazards, WAW,
// starvation throttle, x0 handling and mid-run reset.
module tb_regfile_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        issue_valid_i;
    logic        issue_long_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  rs_a_i;
    logic [4:0]  rs_b_i;
    logic        hazard_o;
    logic        issue_stall_o;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter #(.MAX_WAIT(4), .DATA_W(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_rd_i      (lsu_rd_i),
        .lsu_data_i    (lsu_data_i),
        .issue_valid_i (issue_valid_i),
        .issue_long_i  (issue_long_i),
        .issue_rd_i    (issue_rd_i),
        .rs_a_i        (rs_a_i),
        .rs_b_i        (rs_b_i),
        .hazard_o      (hazard_o),
        .issue_stall_o (issue_stall_o),
        .rd_we_o       (rd_we_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge, checks happen 2ns after.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        alu_valid_i   = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        lsu_valid_i   = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
        issue_valid_i = 1'b0; issue_long_i = 1'b0; issue_rd_i = '0;
        rs_a_i        = '0;   rs_b_i = '0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        issue_valid_i = 1'b1; issue_long_i = 1'b1; issue_rd_i = rd;
    endtask

    task automatic lsu_offer(input logic [4:0] rd, input logic [31:0] d);
        lsu_valid_i = 1'b1; lsu_rd_i = rd; lsu_data_i = d;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        settle();
        chk("rst_hazard", 32'(hazard_o), 32'd0);
        chk("rst_stall",  32'(issue_stall_o), 32'd0);
        chk("rst_we",     32'(rd_we_o), 32'd0);
        chk("rst_ready",  32'(lsu_ready_o), 32'd0);

        // ALU/LSU collision
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'h11;
        lsu_offer(5'd6, 32'h22);
        settle();
        chk("col_addr",  32'(rd_addr_o), 32'd5);
        chk("col_data",  rd_data_o, 32'h11);
        chk("col_we",    32'(rd_we_o), 32'd1);
        chk("col_ready", 32'(lsu_ready_o), 32'd0);
        tick();
        alu_valid_i = 1'b0;
        settle();
        chk("col2_addr",  32'(rd_addr_o), 32'd6);
        chk("col2_data",  rd_data_o, 32'h22);
        chk("col2_ready", 32'(lsu_ready_o), 32'd1);
        tick();
        idle();

        // Load-use hazard on x7
        issue_long(5'd7);
        settle();
        chk("lu_issue_stall", 32'(issue_stall_o), 32'd0);
        tick();
        idle(); rs_a_i = 5'd7;
        settle();
        chk("lu_hazard",  32'(hazard_o), 32'd1);
        chk("lu_stall",   32'(issue_stall_o), 32'd1);
        tick();
        lsu_offer(5'd7, 32'h77);
        settle();
        chk("lu_xfer_hazard", 32'(hazard_o), 32'd1);
        chk("lu_xfer_stall",  32'(issue_stall_o), 32'd1);
        tick();
        lsu_valid_i = 1'b0;
        settle();
        chk("lu_after_hazard", 32'(hazard_o), 32'd0);
        chk("lu_after_stall",  32'(issue_stall_o), 32'd0);
        tick();
        idle();

        // WAW on x9
        issue_long(5'd9);
        tick();
        issue_long(5'd9);
        settle();
        chk("waw_stall", 32'(issue_stall_o), 32'd1);
        lsu_offer(5'd9, 32'h99);
        settle();
        chk("waw_xfer_stall", 32'(issue_stall_o), 32'd0);
        chk("waw_xfer_ready", 32'(lsu_ready_o), 32'd1);
        tick();
        idle(); rs_a_i = 5'd9;
        settle();
        chk("waw_still_set", 32'(hazard_o), 32'd1);
        lsu_offer(5'd9, 32'h9a);
        tick();
        idle(); rs_b_i = 5'd9;
        settle();
        chk("waw_cleared", 32'(hazard_o), 32'd0);
        idle();

        // Starvation throttle
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h1;
        lsu_offer(5'd2, 32'h2);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("starve_pre%0d", i), 32'(issue_stall_o), 32'd0);
            tick();
        end
        settle();
        chk("starve_stall", 32'(issue_stall_o), 32'd1);
        tick();
        settle();
        chk("starve_sat_stall", 32'(issue_stall_o), 32'd1);
        alu_valid_i = 1'b0;
        settle();
        chk("starve_ready", 32'(lsu_ready_o), 32'd1);
        chk("starve_xfer_stall", 32'(issue_stall_o), 32'd1);
        tick();
        lsu_valid_i = 1'b0;
        settle();
        chk("starve_release", 32'(issue_stall_o), 32'd0);
        idle();

        // x0 handling
        issue_long(5'd0);
        settle();
        chk("x0_issue_stall", 32'(issue_stall_o), 32'd0);
        tick();
        idle();
        settle();
        chk("x0_hazard", 32'(hazard_o), 32'd0);
        issue_valid_i = 1'b1; issue_long_i = 1'b1; issue_rd_i = 5'd0;
        settle();
        chk("x0_waw", 32'(issue_stall_o), 32'd0);
        idle();
        lsu_offer(5'd0, 32'h5a);
        settle();
        chk("x0_we",   32'(rd_we_o), 32'd1);
        chk("x0_addr", 32'(rd_addr_o), 32'd0);
        chk("x0_data", rd_data_o, 32'h5a);
        tick();
        idle();

        // Reset mid-operation with x3/x4 pending and wait_cnt non-zero
        issue_long(5'd3);
        tick();
        issue_long(5'd4);
        tick();
        idle();
        alu_valid_i = 1'b1; alu_rd_i = 5'd1;
        lsu_offer(5'd8, 32'h8);
        rs_a_i = 5'd3; rs_b_i = 5'd4;
        settle();
        chk("pre_rst_hazard", 32'(hazard_o), 32'd1);
        tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        settle();
        chk("mid_rst_hazard", 32'(hazard_o), 32'd0);
        chk("mid_rst_stall",  32'(issue_stall_o), 32'd0);
        tick(); tick(); tick();
        settle();
        chk("mid_rst_cnt3", 32'(issue_stall_o), 32'd0);
        tick();
        settle();
        chk("mid_rst_cnt4", 32'(issue_stall_o), 32'd1);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback-port arbiter and scoreboard for the 32x32 integer register file. It merges the single-cycle ALU writeback stream and the long-latency LSU/MUL-DIV writeback stream onto the register file's one write port. It tracks which destination registers have long-latency results outstanding, and raises hazard and issue-stall indications to the decode/issue stage. It sits between the execute/writeback units and the register file write port (address, data, write enable).

## Interface
- MAX_WAIT, 4: cycles a pending long-latency writeback may be refused before issue is throttled (1..15).
- DATA_W, 32: writeback data width.
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- alu_valid_i  in  1  ALU writeback this cycle; never back-pressured.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  DATA_W  ALU result.
- lsu_valid_i  in  1  long-latency result offered.
- lsu_ready_o  out  1  long-latency result accepted this cycle.
- lsu_rd_i  in  5  long-latency destination register.
- lsu_data_i  in  DATA_W  long-latency result.
- issue_valid_i  in  1  decode issuing an instruction this cycle.
- issue_long_i  in  1  the issuing instruction writes via the long-latency path.
- issue_rd_i  in  5  destination of the issuing instruction.
- rs_a_i, rs_b_i  in  5 each  source registers of the instruction in decode.
- hazard_o  out  1  a source register has an outstanding long-latency write.
- issue_stall_o  out  1  decode must not issue this cycle.
- rd_we_o  out  1  register file write enable.
- rd_addr_o  out  5  register file write address.
- rd_data_o  out  DATA_W  register file write data.

## Operation
- The write port is combinational pass-through.
  - ALU has strict priority: if alu_valid_i, drive rd_* from the ALU.
  - Otherwise, if lsu_valid_i, drive rd_* from the LSU.
  - rd_we_o = alu_valid_i | lsu_valid_i.
- lsu_ready_o = lsu_valid_i & ~alu_valid_i. A transfer occurs when valid and ready are both high. The LSU holds rd and data stable while it is refused.
- Writes with rd = 0 are forwarded unchanged; the register file discards them.
- Scoreboard: 32-bit pending vector; bit 0 is hard-wired 0.
  - Set bit issue_rd_i when issue_valid_i & issue_long_i & ~issue_stall_o & issue_rd_i != 0.
  - Clear bit lsu_rd_i on an LSU transfer.
  - If set and clear hit the same index in the same cycle, set wins.
- hazard_o = pending[rs_a_i] | pending[rs_b_i], from registered state only.
  - It deasserts the cycle after the LSU transfer, when the register file already holds the data.
  - No forwarding is performed.
- issue_stall_o is asserted when any of the following holds:
  - hazard_o;
  - WAW: issue_valid_i and pending[issue_rd_i], unless an LSU transfer to that same rd happens this cycle;
  - starvation throttle: wait_cnt == MAX_WAIT.
- Starvation counter wait_cnt (4 bits):
  - increments, saturating at MAX_WAIT, each cycle lsu_valid_i & ~lsu_ready_o;
  - clears on an LSU transfer or when lsu_valid_i is low.
  - When saturated, issue stalls. The ALU stream then drains within pipeline depth, and the LSU obtains the port.

## Timing
- Reset: pending = 0 and wait_cnt = 0. Resulting outputs: hazard_o = 0, issue_stall_o = 0 (given idle inputs), rd_we_o = 0, lsu_ready_o = 0.
- Write-port latency: 0 cycles. The register file captures the write at the next edge.
- Scoreboard set and clear take effect at the edge following the event.
- Reset asserted mid-operation clears all pending bits. Upstream flushes outstanding long ops under the same reset.
- issue_stall_o depends combinationally on issue_* and lsu_* inputs. Decode must not feed issue_valid_i from issue_stall_o.

## Structure
- The shared core package holds:
  - a REG_ADDR_W = 5 constant;
  - an NREGS = 32 constant;
  - a wb_req_t struct {valid, rd, data} used by both writeback sources.
- One sub-module, wb_scoreboard: holds the pending vector, set/clear/priority logic and the hazard/WAW lookups.
- The arbiter mux and starvation counter live in the top module.

## Test plan
- ALU/LSU collision: ALU writes x5 = 0x11 while LSU offers x6 = 0x22 in the same cycle.
  - That cycle: rd_addr_o = 5 and lsu_ready_o = 0.
  - Next cycle, with the ALU idle: x6 is written and lsu_ready_o = 1.
- Load-use hazard: issue a long op to x7, then present rs_a_i = 7.
  - hazard_o = 1 and issue_stall_o = 1 until the LSU transfer to x7.
  - Both drop the following cycle.
- WAW on x9:
  - Issuing long to x9 while x9 is pending stalls.
  - An LSU transfer to x9 in that same cycle lets it issue; the bit stays set.
- Starvation with MAX_WAIT = 4: hold ALU valid every cycle while the LSU is valid.
  - issue_stall_o rises after 4 refusals.
  - It falls the cycle after the LSU transfer.
- x0 handling: issue long with rd = 0.
  - No pending bit is set and there is no hazard on rs = 0.
  - An LSU write to x0 passes through with rd_we_o = 1.
- Reset mid-operation: with x3 and x4 pending, pulse rst_i for 1 cycle.
  - All hazard flags clear and wait_cnt = 0.
